// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx
//  Description : Host-to-device PS/2 command transmitter driving open-drain
//                clock/data enables, with valid/ready byte input and
//                done/error completion pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int c_MAX_CYC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);

    localparam logic [c_CNT_W-1:0] c_INH_LAST = c_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]         c_IDX_STOP = 4'd10;

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_INHIBIT   = 3'd1;
    localparam logic [2:0] c_START     = 3'd2;
    localparam logic [2:0] c_SHIFT     = 3'd3;
    localparam logic [2:0] c_ACK_CHECK = 3'd4;
    localparam logic [2:0] c_WAIT_IDLE = 3'd5;
    localparam logic [2:0] c_ERROR     = 3'd6;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [10:0]        r_frame;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_idx;
    logic               r_clk_s1;
    logic               r_clk_sync;
    logic               r_clk_prev;
    logic               r_fall;
    logic               r_data_s1;
    logic               r_data_sync;
    logic               w_timeout;

    assign w_timeout = (r_cnt == c_TMO_LAST);

    // Synchronizers idle high so reset never fabricates a falling edge
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_clk_s1    <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_clk_prev  <= 1'b1;
            r_fall      <= 1'b0;
            r_data_s1   <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            r_clk_s1    <= ps2_clk_in;
            r_clk_sync  <= r_clk_s1;
            r_clk_prev  <= r_clk_sync;
            r_fall      <= r_clk_prev & ~r_clk_sync;
            r_data_s1   <= ps2_data_in;
            r_data_sync <= r_data_s1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= c_IDLE;
            r_frame <= 11'h7ff;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                c_IDLE: begin
                    if (tx_valid) begin
                        r_frame <= {1'b1, ~^tx_data, tx_data, 1'b0};
                        r_cnt   <= '0;
                    end
                end
                c_INHIBIT: r_cnt <= r_cnt + c_CNT_W'(1);
                c_START: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                end
                c_SHIFT: begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (r_fall && (r_idx != c_IDX_STOP)) begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                c_ACK_CHECK, c_WAIT_IDLE: r_cnt <= r_cnt + c_CNT_W'(1);
                default: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                end
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        tx_ready     = 1'b0;
        tx_done      = 1'b0;
        tx_error     = 1'b0;
        ps2_clk_oe   = 1'b0;
        ps2_data_oe  = 1'b0;
        busy         = (r_state != c_IDLE);
        case (r_state)
            c_IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) w_next_state = c_INHIBIT;
            end
            c_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (r_cnt == c_INH_LAST) w_next_state = c_START;
            end
            c_START: begin
                ps2_clk_oe   = 1'b1;
                ps2_data_oe  = 1'b1;
                w_next_state = c_SHIFT;
            end
            c_SHIFT: begin
                ps2_data_oe = ~r_frame[r_idx];
                if (w_timeout) w_next_state = c_ERROR;
                else if (r_fall && (r_idx == c_IDX_STOP)) w_next_state = c_ACK_CHECK;
            end
            c_ACK_CHECK: begin
                if (w_timeout || r_data_sync) w_next_state = c_ERROR;
                else w_next_state = c_WAIT_IDLE;
            end
            c_WAIT_IDLE: begin
                // Timeout wins so done and error can never both fire for one frame
                if (w_timeout) begin
                    w_next_state = c_ERROR;
                end else if (r_clk_sync && r_data_sync) begin
                    tx_done      = 1'b1;
                    w_next_state = c_IDLE;
                end
            end
            c_ERROR: begin
                tx_error     = 1'b1;
                w_next_state = c_IDLE;
            end
            default: w_next_state = c_IDLE;
        endcase
    end

endmodule
`default_nettype wire
